// File: rtl/pwm_pkg.sv
// Shared types and constants for the dead-time gate driver.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DEAD = 2'd1,
      HI   = 2'd2,
      LO   = 2'd3
   } state_t;

   localparam int DT_WIDTH_DEF = 8;

endpackage

// File: rtl/pwm_deadtime_if.sv
// Per-lane PWM/gate bundle between the gate driver and its phase engines.
interface pwm_deadtime_if #(
   parameter int W        = 1,
   parameter int DT_WIDTH = 8
);

   logic                ena;
   logic [DT_WIDTH-1:0] dt_cycles;
   logic [W-1:0]        pwm;
   logic [W-1:0]        gate_hi;
   logic [W-1:0]        gate_lo;

   modport master (
      output ena, dt_cycles, pwm,
      input  gate_hi, gate_lo
   );

   modport slave (
      input  ena, dt_cycles, pwm,
      output gate_hi, gate_lo
   );

endinterface

// File: rtl/pwm_deadtime_phase.sv
// One phase: dead-time FSM, target bit and saturating down-counter.
module pwm_deadtime_phase
   import pwm_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input logic           clk,
   input logic           rst,
   pwm_deadtime_if.slave bus
);

   localparam logic [DT_WIDTH-1:0] ONE =
      {{(DT_WIDTH-1){1'b0}}, 1'b1};

   state_t              st, nxt;
   logic                tgt, tgt_n;
   logic [DT_WIDTH-1:0] cnt, cnt_n;
   logic                hi_q, lo_q;
   logic                p;

   assign p = bus.pwm[0];

   always_comb begin
      nxt   = st;
      tgt_n = tgt;
      cnt_n = cnt;
      if (!bus.ena) begin
         nxt = IDLE;
      end else begin
         unique case (st)
            IDLE: begin
               nxt   = DEAD;
               tgt_n = p;
               cnt_n = bus.dt_cycles;
            end
            DEAD: begin
               // A flip mid-interval restarts the full dead time.
               if (p != tgt) begin
                  tgt_n = p;
                  cnt_n = bus.dt_cycles;
               end else if (cnt <= ONE) begin
                  nxt   = tgt ? HI : LO;
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt - ONE;
               end
            end
            HI: begin
               if (!p) begin
                  nxt   = DEAD;
                  tgt_n = 1'b0;
                  cnt_n = bus.dt_cycles;
               end
            end
            LO: begin
               if (p) begin
                  nxt   = DEAD;
                  tgt_n = 1'b1;
                  cnt_n = bus.dt_cycles;
               end
            end
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st   <= IDLE;
         tgt  <= 1'b0;
         cnt  <= '0;
         hi_q <= 1'b0;
         lo_q <= 1'b0;
      end else begin
         st   <= nxt;
         tgt  <= tgt_n;
         cnt  <= cnt_n;
         hi_q <= (nxt == HI);
         lo_q <= (nxt == LO);
      end
   end

   assign bus.gate_hi = hi_q;
   assign bus.gate_lo = lo_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-phase dead-time gate driver; shoot-through checker under
// PWM_DEADTIME_FAULT_EN.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int PHASES   = 1,
   parameter int DT_WIDTH = DT_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [DT_WIDTH-1:0] dt_cycles,
   input  logic [PHASES-1:0]   pwm_in,
   input  logic [PHASES-1:0]   pwm_n_in,
   input  logic                fault_clr,
   output logic [PHASES-1:0]   gate_hi,
   output logic [PHASES-1:0]   gate_lo,
   output logic                fault
);

   logic run;

`ifdef PWM_DEADTIME_FAULT_EN
   logic fault_q;
   logic overlap;

   assign overlap = |(pwm_in & pwm_n_in);

   // A new overlap beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fault_q <= 1'b0;
      end else if (overlap) begin
         fault_q <= 1'b1;
      end else if (fault_clr) begin
         fault_q <= 1'b0;
      end
   end

   assign fault = fault_q;
   assign run   = ena & ~fault_q & ~overlap;
`else
   logic unused_in;

   assign unused_in = ^{pwm_n_in, fault_clr};
   assign fault     = 1'b0;
   assign run       = ena;
`endif

   for (genvar i = 0; i < PHASES; i++) begin : g_ph
      pwm_deadtime_if #(
         .W        (1),
         .DT_WIDTH (DT_WIDTH)
      ) ph ();

      assign ph.ena       = run;
      assign ph.dt_cycles = dt_cycles;
      assign ph.pwm       = pwm_in[i];
      assign gate_hi[i]   = ph.gate_hi[0];
      assign gate_lo[i]   = ph.gate_lo[0];

      pwm_deadtime_phase #(
         .DT_WIDTH (DT_WIDTH)
      ) u_ph (
         .clk (clk),
         .rst (rst),
         .bus (ph)
      );
   end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter PHASES, default 1, number of independent PWM phases.
REQ-002 SHALL have parameter DT_WIDTH, default 8, width of the dead-time count.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  global enable; 0 forces all gates low.
REQ-006 SHALL have port dt_cycles  input  DT_WIDTH  dead-time length in clk cycles.
REQ-007 SHALL have port pwm_in  input  PHASES  raw PWM from the PWM stage, same clock domain.
REQ-008 SHALL have port pwm_n_in  input  PHASES  complementary raw PWM, used only by the fault checker.
REQ-009 SHALL have port fault_clr  input  1  single-cycle fault clear pulse.
REQ-010 SHALL have port gate_hi  output  PHASES  high-side gate drive, registered.
REQ-011 SHALL have port gate_lo  output  PHASES  low-side gate drive, registered.
REQ-012 SHALL have port fault  output  1  latched shoot-through fault flag, registered.

Function
REQ-013 Each phase SHALL run an independent FSM with states IDLE, DEAD, HI, LO, plus a target bit and a DT_WIDTH down-counter.
REQ-014 IDLE: gate_hi=gate_lo=0; when ena=1, go to DEAD, target<=pwm_in, counter<=dt_cycles.
REQ-015 DEAD: both gates 0; counter decrements each cycle; at counter==0 go to HI if target=1, else LO.
REQ-016 dt_cycles=N SHALL give exactly max(N,1) cycles with both gates low between any hi/lo transition.
REQ-017 DEAD with pwm_in!=target: target<=pwm_in, counter reloaded from dt_cycles (dead interval restarts).
REQ-018 HI: gate_hi=1; pwm_in=0 -> DEAD, target 0, counter loaded. LO: gate_lo=1; pwm_in=1 -> DEAD, target 1, counter loaded.
REQ-019 pwm_in pulses shorter than the dead interval SHALL be swallowed; gates never both 1 in any cycle.
REQ-020 dt_cycles SHALL be sampled only at counter load; changes mid-interval do not affect the running interval.
REQ-021 ena deasserted in any state -> IDLE next cycle, gates 0 next cycle.
REQ-022 Edge latency pwm_in -> opposite gate on = max(dt_cycles,1)+1 cycles; gate off = 1 cycle.
REQ-023 Arithmetic: counter is DT_WIDTH bits unsigned, never wraps below 0; dt_cycles = 2^DT_WIDTH-1 is legal.

Reset
REQ-024 Asserting rst low SHALL asynchronously force all FSMs to IDLE, counters 0, targets 0, gate_hi=0, gate_lo=0, fault=0.
REQ-025 Reset mid-DEAD or mid-HI SHALL drop gates immediately, without waiting for clk; release resumes via IDLE.

Configuration
REQ-026 Macro PWM_DEADTIME_FAULT_EN SHALL compile in the shoot-through checker.
REQ-027 With it: fault<=1 in any cycle where pwm_in[i]&pwm_n_in[i] for any i; fault_clr clears; set wins over a simultaneous clear.
REQ-028 With it: while fault=1 all FSMs held in IDLE, all gates 0; resumption after clear goes through DEAD.
REQ-029 Without it: fault tied 0, pwm_n_in and fault_clr unused, no checker logic present.

Structure
REQ-030 Shared package pwm_pkg SHALL hold the FSM state encoding and the default DT_WIDTH constant.
REQ-031 One sub-module pwm_deadtime_phase (FSM + counter for one phase) SHALL be instanced PHASES times via generate; the fault checker stays in the top.

Verification
REQ-032 dt_cycles=4, ena=1, pwm_in 0->1 -> gate_lo falls 1 cycle later, gate_hi rises 5 cycles after the edge, 4 cycles both low.
REQ-033 dt_cycles=0, pwm_in toggling every 3 cycles -> exactly 1 both-low cycle per transition, never overlap.
REQ-034 dt_cycles=10, 3-cycle pwm_in high pulse from LO -> gate_hi never asserts, gate_lo returns after 10 dead cycles from pulse end.
REQ-035 ena 1->0 while gate_hi=1 -> gate_hi=0 next cycle, both gates held 0 while ena=0.
REQ-036 (PWM_DEADTIME_FAULT_EN) pwm_in=pwm_n_in=1 for 1 cycle -> fault=1, gates 0; fault_clr with overlap present -> fault stays 1; clear after overlap gone -> fault=0, gates resume after dead interval.
REQ-037 rst low asynchronously mid-DEAD with dt_cycles=200 -> gates and fault 0 before the next clk edge; release -> normal sequence from IDLE.
